csla_seq_ctrl: RTL and testbench
================================

Name: csla_seq_ctrl

Overview:
Sequencing controller that computes wide additions by time-multiplexing one CSLA4Bit 4-bit carry-select adder slice. It processes one nibble per cycle from LSB to MSB and keeps the carry in a register between cycles. Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake. The block is the nibble-serial wide-add engine for the adder datapath.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range >= 1.

Ports:
Clk  in  1  clock; all state updates on rising edge.
Rst  in  1  reset, asynchronous, active-high.
InValid  in  1  operand request.
InReady  out  1  controller can accept operands (high only in IDLE).
A  in  W  operand A, sampled on accept.
B  in  W  operand B, sampled on accept.
Cin  in  1  carry-in, sampled on accept.
OutValid  out  1  result available.
OutReady  in  1  consumer takes result.
S  out  W  sum, registered.
Cout  out  1  carry out of the top nibble, registered.
Busy  out  1  high in RUN and DONE.

Behaviour:
- Reset values (async, immediate on Rst=1):
  - state = IDLE; OutValid = 0; S = 0; Cout = 0; Busy = 0; InReady = 1.
  - Internal operand, carry, index and work registers are cleared.
- States and transitions:
  - IDLE: InReady = 1. On a clock edge with InValid = 1, capture A, B and Cin into internal registers, set idx = 0, carry reg = Cin, go to RUN.
  - RUN: drive CSLA4Bit with A_reg[4*idx+:4], B_reg[4*idx+:4] and the carry reg. Each edge: work[4*idx+:4] <= slice S; carry <= slice Cout; idx <= idx+1. On the edge that processes idx = NIBBLES-1, load S <= final work value, Cout <= slice Cout, OutValid <= 1, go to DONE.
  - DONE: OutValid = 1; S and Cout are stable. On an edge with OutReady = 1: OutValid <= 0, go to IDLE. S and Cout keep their last value until the next DONE load.
- Latency:
  - If the accept edge is t, OutValid is first high after edge t+NIBBLES.
  - Minimum spacing between accepts is NIBBLES+2 edges, because InReady is low in RUN and DONE.
  - There is no same-cycle DONE->accept bypass.
- Arithmetic:
  - {Cout,S} = A + B + Cin, exact, W+1 bits.
  - S wraps modulo 2^W and Cout carries the overflow.
  - The carry is never reset between nibbles of one operation.
- Input isolation: A, B, Cin and InValid are ignored outside IDLE. Operand changes after accept have no effect on the in-flight result.
- Backpressure: in DONE with OutReady = 0, the block holds OutValid, S and Cout indefinitely.
- OutReady outside DONE has no effect.
- Reset mid-operation (RUN or DONE): the operation is aborted, no OutValid pulse is produced, all outputs return to reset values.
- NIBBLES = 1: RUN lasts exactly one cycle.
- idx counter width is clog2(NIBBLES), minimum 1 bit, and must not wrap inside RUN.
- Outputs are registered, except InReady and Busy, which are decoded from state.

Test Plan:
1. Reset: assert Rst asynchronously, mid-cycle, while in RUN -> OutValid=0, S=0, Cout=0, Busy=0 and InReady=1 immediately; no OutValid follows after release.
2. NIBBLES=4, A=16'hFFFF, B=16'h0000, Cin=1 -> S=16'h0000, Cout=1; OutValid high exactly 4 edges after the accept edge; Busy high from accept until OutReady.
3. NIBBLES=4, A=16'h1234, B=16'h4321, Cin=0 -> S=16'h5555, Cout=0. Then A=16'h0FFF, B=16'h0001, Cin=0 -> S=16'h1000, Cout=0 (carry ripples across three nibbles).
4. Backpressure: hold OutReady=0 for 6 cycles in DONE while InValid=1 with new operands A=16'hAAAA, B=16'h5555 -> OutValid, S and Cout stay constant and InReady=0. Then pulse OutReady -> IDLE, and the new operands are accepted next edge, giving S=16'hFFFF, Cout=0.
5. Operand change after accept: accept A=16'h0001, B=16'h0001, then change A/B every cycle during RUN -> S=16'h0002.
6. NIBBLES=1 build: A=4'hF, B=4'h0, Cin=1 -> S=4'h0, Cout=1, OutValid 1 edge after accept. Also A=4'h7, B=4'h8, Cin=0 -> S=4'hF, Cout=0.

Source files
------------

// File: rtl/csla_seq_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial wide-add engine.
// The master side supplies operands and consumes results; the slave is the controller.
interface csla_seq_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready_c;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         busy_c;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready_c, out_valid, s, cout, busy_c
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready_c, out_valid, s, cout, busy_c
  );
endinterface

// File: rtl/csla_seq_ctrl.sv
// Nibble-serial wide adder: one 4-bit carry-select slice reused LSB to MSB,
// with the inter-nibble carry held in a register across cycles.

// 4-bit carry-select slice: low pair ripples, high pair is precomputed for both carries.
module csla4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [2:0] lo_sum;
  logic [2:0] hi_sum0;
  logic [2:0] hi_sum1;
  logic [2:0] hi_sel;

  assign lo_sum  = 3'(a_i[1:0]) + 3'(b_i[1:0]) + 3'(c_i);
  assign hi_sum0 = 3'(a_i[3:2]) + 3'(b_i[3:2]);
  assign hi_sum1 = hi_sum0 + 3'd1;
  assign hi_sel  = lo_sum[2] ? hi_sum1 : hi_sum0;
  assign s_o     = {hi_sel[1:0], lo_sum[1:0]};
  assign c_o     = hi_sel[2];
endmodule

module csla_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  csla_seq_ctrl_if.slave       bus_if
);
  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       work_q, work_d;
  logic [W-1:0]       s_q, s_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;

  logic [IDX_W+1:0]   bit_ofs;
  logic [3:0]         slice_a;
  logic [3:0]         slice_b;
  logic [3:0]         slice_s;
  logic               slice_cout;
  logic [W-1:0]       work_upd;
  logic               in_ready_c;
  logic               busy_c;

  // Current nibble is selected by shifting, so no out-of-range part-select exists.
  assign bit_ofs  = {idx_q, 2'b00};
  assign slice_a  = 4'(a_q >> bit_ofs);
  assign slice_b  = 4'(b_q >> bit_ofs);
  assign work_upd = (work_q & ~(W'(4'hF) << bit_ofs)) | (W'(slice_s) << bit_ofs);

  csla4bit u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_cout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      work_q      <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      work_q      <= work_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and decoded outputs; operands are only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    work_d      = work_q;
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    in_ready_c  = 1'b0;
    busy_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus_if.in_valid) begin
          a_d     = bus_if.a;
          b_d     = bus_if.b;
          carry_d = bus_if.cin;
          idx_d   = '0;
          work_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c  = 1'b1;
        work_d  = work_upd;
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          s_d         = work_upd;
          cout_d      = slice_cout;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_c = 1'b1;
        if (bus_if.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_if.in_ready_c = in_ready_c;
  assign bus_if.busy_c     = busy_c;
  assign bus_if.out_valid  = out_valid_q;
  assign bus_if.s          = s_q;
  assign bus_if.cout       = cout_q;
endmodule

// File: tb/tb_csla_seq_ctrl.sv
// Directed bench for csla_seq_ctrl: a 4-nibble and a 1-nibble instance share clock and reset.
module tb_csla_seq_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  csla_seq_ctrl_if #(.NIBBLES(4)) bus4 ();
  csla_seq_ctrl_if #(.NIBBLES(1)) bus1 ();

  csla_seq_ctrl #(.NIBBLES(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus_if(bus4.slave));
  csla_seq_ctrl #(.NIBBLES(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus_if(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation into the 4-nibble DUT and waits (bounded) for the result.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input bit scramble, output logic [15:0] s, output logic cout,
                      output int lat);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      if (scramble) begin
        bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.cin = 1'($urandom);
      end
      step();
      lat++;
    end
    if (bus4.out_valid !== 1'b1) lat = -1;
    s = bus4.s;
    cout = bus4.cout;
  endtask

  task automatic release4();
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      output logic [3:0] s, output logic cout, output int lat);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    lat = 0;
    while (bus1.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    if (bus1.out_valid !== 1'b1) lat = -1;
    s = bus1.s;
    cout = bus1.cout;
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({bus4.out_valid, bus4.s, bus4.cout, bus4.busy_c, bus4.in_ready_c} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset4 got ov=%b s=%h co=%b busy=%b rdy=%b exp ov=0 s=0000 co=0 busy=0 rdy=1",
               bus4.out_valid, bus4.s, bus4.cout, bus4.busy_c, bus4.in_ready_c);
    end
    checks++;
    if ({bus1.out_valid, bus1.s, bus1.cout, bus1.busy_c, bus1.in_ready_c} !== {1'b0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset1 got ov=%b s=%h co=%b busy=%b rdy=%b exp ov=0 s=0 co=0 busy=0 rdy=1",
               bus1.out_valid, bus1.s, bus1.cout, bus1.busy_c, bus1.in_ready_c);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_carry_all();
    bit early;
    bus4.a = 16'hFFFF; bus4.b = 16'h0000; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    checks++;
    if ({bus4.busy_c, bus4.in_ready_c, bus4.out_valid} !== 3'b100) begin
      failures++;
      $display("FAIL accept_state got busy=%b rdy=%b ov=%b exp 1 0 0", bus4.busy_c, bus4.in_ready_c, bus4.out_valid);
    end
    early = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      if (bus4.out_valid !== 1'b0 || bus4.busy_c !== 1'b1) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL latency_early got ov/busy wrong before edge 4 exp ov=0 busy=1");
    end
    step();
    checks++;
    if ({bus4.out_valid, bus4.busy_c, bus4.s, bus4.cout} !== {1'b1, 1'b1, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL carry_all got ov=%b busy=%b s=%h co=%b exp ov=1 busy=1 s=0000 co=1",
               bus4.out_valid, bus4.busy_c, bus4.s, bus4.cout);
    end
    release4();
    checks++;
    if ({bus4.out_valid, bus4.busy_c, bus4.in_ready_c} !== 3'b001) begin
      failures++;
      $display("FAIL release got ov=%b busy=%b rdy=%b exp 0 0 1", bus4.out_valid, bus4.busy_c, bus4.in_ready_c);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] s;
    logic        co;
    int          lat;
    logic [48:0] vec [3];
    vec[0] = {16'h1234, 16'h4321, 1'b0, 16'h5555};
    vec[1] = {16'h0FFF, 16'h0001, 1'b0, 16'h1000};
    vec[2] = {16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      run4(vec[i][48:33], vec[i][32:17], vec[i][16], 1'b0, s, co, lat);
      checks++;
      if ({lat, s, co} !== {32'sd4, vec[i][15:0], (i == 2) ? 1'b1 : 1'b0}) begin
        failures++;
        $display("FAIL pattern%0d got lat=%0d s=%h co=%b exp lat=4 s=%h co=%b",
                 i, lat, s, co, vec[i][15:0], (i == 2) ? 1'b1 : 1'b0);
      end
      release4();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] s;
    logic        co;
    int          lat;
    bit          moved;
    run4(16'h0FFF, 16'h0001, 1'b0, 1'b0, s, co, lat);
    bus4.a = 16'hAAAA; bus4.b = 16'h5555; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    moved = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if ({bus4.out_valid, bus4.s, bus4.cout, bus4.in_ready_c} !== {1'b1, 16'h1000, 1'b0, 1'b0}) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      failures++;
      $display("FAIL hold got ov=%b s=%h co=%b rdy=%b exp ov=1 s=1000 co=0 rdy=0",
               bus4.out_valid, bus4.s, bus4.cout, bus4.in_ready_c);
    end
    release4();
    checks++;
    if ({bus4.out_valid, bus4.in_ready_c} !== 2'b01) begin
      failures++;
      $display("FAIL bp_idle got ov=%b rdy=%b exp ov=0 rdy=1", bus4.out_valid, bus4.in_ready_c);
    end
    step();
    bus4.in_valid = 1'b0;
    checks++;
    if (bus4.busy_c !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept got busy=%b exp 1", bus4.busy_c);
    end
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if ({lat, bus4.s, bus4.cout} !== {32'sd4, 16'hFFFF, 1'b0}) begin
      failures++;
      $display("FAIL bp_result got lat=%0d s=%h co=%b exp lat=4 s=ffff co=0", lat, bus4.s, bus4.cout);
    end
    release4();
  endtask

  task automatic test_isolation();
    logic [15:0] s;
    logic        co;
    int          lat;
    run4(16'h0001, 16'h0001, 1'b0, 1'b1, s, co, lat);
    checks++;
    if ({lat, s, co} !== {32'sd4, 16'h0002, 1'b0}) begin
      failures++;
      $display("FAIL isolation got lat=%0d s=%h co=%b exp lat=4 s=0002 co=0", lat, s, co);
    end
    release4();
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    bus4.a = 16'h1234; bus4.b = 16'h4321; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus4.out_valid, bus4.s, bus4.cout, bus4.busy_c, bus4.in_ready_c} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset got ov=%b s=%h co=%b busy=%b rdy=%b exp ov=0 s=0000 co=0 busy=0 rdy=1",
               bus4.out_valid, bus4.s, bus4.cout, bus4.busy_c, bus4.in_ready_c);
    end
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus4.out_valid !== 1'b0 || bus4.in_ready_c !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL after_reset got ov=%b rdy=%b exp ov=0 rdy=1 throughout", bus4.out_valid, bus4.in_ready_c);
    end
  endtask

  task automatic test_nibbles1();
    logic [3:0] s;
    logic       co;
    int         lat;
    run1(4'hF, 4'h0, 1'b1, s, co, lat);
    checks++;
    if ({lat, s, co} !== {32'sd1, 4'h0, 1'b1}) begin
      failures++;
      $display("FAIL n1_carry got lat=%0d s=%h co=%b exp lat=1 s=0 co=1", lat, s, co);
    end
    run1(4'h7, 4'h8, 1'b0, s, co, lat);
    checks++;
    if ({lat, s, co} !== {32'sd1, 4'hF, 1'b0}) begin
      failures++;
      $display("FAIL n1_plain got lat=%0d s=%h co=%b exp lat=1 s=f co=0", lat, s, co);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_carry_all();
    test_patterns();
    test_backpressure();
    test_isolation();
    test_reset_mid_run();
    test_nibbles1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
